midi_note_ctrl: RTL and testbench

MIDI_NOTE_CTRL -- requirements
Module: midi_note_ctrl

---
 rtl/midi_note_ctrl_pkg.sv | 24 ++
 rtl/midi_note_ctrl_divmod12.sv | 49 ++++
 rtl/midi_note_ctrl.sv | 145 ++++++++++++++
 tb/tb_midi_note_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_note_ctrl_pkg.sv
// Shared types and constants for the MIDI note controller: parser states,
// MIDI status nibbles and the top-octave pitch table.
package midi_note_ctrl_pkg;

   typedef enum logic [1:0] {
      NO_STATUS = 2'd0,
      WAIT_D1   = 2'd1,
      WAIT_D2   = 2'd2,
      CALC      = 2'd3
   } state_t;

   localparam logic [3:0] NOTE_ON   = 4'h9;
   localparam logic [3:0] NOTE_OFF  = 4'h8;
   localparam logic [7:0] RT_MIN    = 8'hF8;
   localparam logic [3:0] DIV_ITERS = 4'd11;

   // Phase increment for semitone 'semi' of octave 10 (key/12 numbering, A10 = 14080 Hz).
   function automatic logic [63:0] PITCH_TBL(input int semi, input int acc_w, input int clk_hz);
      real f_hz;
      f_hz = 14080.0 * (2.0 ** ((real'(semi) - 9.0) / 12.0));
      return 64'(longint'(f_hz * (2.0 ** acc_w) / real'(clk_hz)));
   endfunction

endpackage

// File: rtl/midi_note_ctrl_divmod12.sv
// note_divmod12: key -> octave (key/12) and semitone (key%12) by eleven
// conditional subtract-12 steps; done rises exactly 11 cycles after start.
module note_divmod12
   import midi_note_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic [6:0] i_key,
   output logic       o_done,
   output logic [3:0] o_octave,
   output logic [3:0] o_semi
);

   logic [6:0] r_rem;
   logic [3:0] r_quo;
   logic [3:0] r_cnt;
   logic       r_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_rem  <= i_key;
         r_quo  <= '0;
         r_cnt  <= DIV_ITERS;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (r_cnt != 4'd0) begin
            if (r_rem >= 7'd12) begin
               r_rem <= r_rem - 7'd12;
               r_quo <= r_quo + 4'd1;
            end
            r_cnt <= r_cnt - 4'd1;
         end else begin
            r_busy <= 1'b0;
         end
      end
   end

   // Key <= 127 leaves the remainder below 12 after eleven steps.
   assign o_done   = r_busy && (r_cnt == 4'd0);
   assign o_octave = r_quo;
   assign o_semi   = r_rem[3:0];

endmodule

// File: rtl/midi_note_ctrl.sv
// MIDI note-on/off parser with running status, last-note priority and a
// multi-cycle pitch calculation driving the oscillator phase increment.
module midi_note_ctrl
   import midi_note_ctrl_pkg::*;
#(
   parameter int PHASE_ACC_WIDTH = 30,
   parameter int CLK_HZ          = 100_000_000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_valid,
   output logic                       rx_ready,
   input  logic [3:0]                 midi_ch,
   output logic [PHASE_ACC_WIDTH-1:0] fccw,
   output logic                       gate,
   output logic [6:0]                 note_num,
   output logic [6:0]                 velocity,
   output logic                       retrig,
   output logic                       err
);

   state_t r_state;
   state_t w_state_next;

   logic                       r_run_on;
   logic [6:0]                 r_key;
   logic [6:0]                 r_vel;
   logic                       r_off_pend;
   logic [PHASE_ACC_WIDTH-1:0] r_fccw;
   logic                       r_gate;
   logic [6:0]                 r_note;
   logic [6:0]                 r_velocity;
   logic                       r_retrig;
   logic                       r_err;

   logic w_accept, w_is_rt, w_ch_match;
   logic w_set_run, w_clr_run, w_latch_key, w_start, w_off_hit, w_orphan;
   logic w_done;
   logic [3:0] w_oct, w_semi;
   logic [PHASE_ACC_WIDTH-1:0] w_tbl [16];
   logic [PHASE_ACC_WIDTH-1:0] w_fccw;

   for (genvar gi = 0; gi < 16; gi++) begin : g_tbl
      localparam logic [63:0] TBL_WORD = (gi < 12) ? PITCH_TBL(gi, PHASE_ACC_WIDTH, CLK_HZ) : 64'd0;
      assign w_tbl[gi] = TBL_WORD[PHASE_ACC_WIDTH-1:0];
   end

   assign w_fccw     = w_tbl[w_semi] >> (4'd10 - w_oct);
   assign rx_ready   = (r_state != CALC);
   assign w_accept   = rx_valid && rx_ready;
   assign w_is_rt    = (rx_data >= RT_MIN);
   assign w_ch_match = (rx_data[3:0] == midi_ch) &&
                       ((rx_data[7:4] == NOTE_ON) || (rx_data[7:4] == NOTE_OFF));

   note_divmod12 u_divmod (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_start),
      .i_key    (r_key),
      .o_done   (w_done),
      .o_octave (w_oct),
      .o_semi   (w_semi)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= NO_STATUS;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_set_run    = 1'b0;
      w_clr_run    = 1'b0;
      w_latch_key  = 1'b0;
      w_start      = 1'b0;
      w_off_hit    = 1'b0;
      w_orphan     = 1'b0;
      if (r_state == CALC) begin
         if (w_done) w_state_next = WAIT_D1;
      end else if (w_accept && !w_is_rt) begin
         if (rx_data[7]) begin
            if (w_ch_match) begin
               w_set_run    = 1'b1;
               w_state_next = WAIT_D1;
            end else begin
               w_clr_run    = 1'b1;
               w_state_next = NO_STATUS;
            end
         end else if (r_state == NO_STATUS) begin
            w_orphan = 1'b1;
         end else if (r_state == WAIT_D1) begin
            w_latch_key  = 1'b1;
            w_state_next = WAIT_D2;
         end else if (r_run_on && (rx_data != 8'h00)) begin
            w_start      = 1'b1;
            w_state_next = CALC;
         end else begin
            // Note-off (explicit or zero velocity) only releases the sounding key.
            w_off_hit    = (r_key == r_note);
            w_state_next = WAIT_D1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_run_on   <= 1'b0;
         r_key      <= '0;
         r_vel      <= '0;
         r_off_pend <= 1'b0;
         r_fccw     <= '0;
         r_gate     <= 1'b0;
         r_note     <= '0;
         r_velocity <= '0;
         r_retrig   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_retrig   <= 1'b0;
         r_err      <= w_orphan;
         r_off_pend <= w_off_hit;
         if (w_set_run)      r_run_on <= (rx_data[7:4] == NOTE_ON);
         else if (w_clr_run) r_run_on <= 1'b0;
         if (w_latch_key) r_key <= rx_data[6:0];
         if (w_start)     r_vel <= rx_data[6:0];
         if ((r_state == CALC) && w_done) begin
            r_fccw     <= w_fccw;
            r_note     <= r_key;
            r_velocity <= r_vel;
            r_gate     <= 1'b1;
            r_retrig   <= 1'b1;
         end else if (r_off_pend) begin
            r_gate <= 1'b0;
         end
      end
   end

   assign fccw     = r_fccw;
   assign gate     = r_gate;
   assign note_num = r_note;
   assign velocity = r_velocity;
   assign retrig   = r_retrig;
   assign err      = r_err;

endmodule

// File: tb/tb_midi_note_ctrl.sv
// Bench for midi_note_ctrl: directed MIDI scenarios plus a random byte stream
// checked against a message-level model of the note controller.
module tb_midi_note_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [3:0]  midi_ch = 4'h0;
   logic [29:0] fccw;
   logic        gate;
   logic [6:0]  note_num;
   logic [6:0]  velocity;
   logic        retrig;
   logic        err;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_acc = 0;

   // message-level model state
   int          m_run = 0;   // 0 none, 9 note-on, 8 note-off
   int          m_idx = 0;   // 0 expecting key, 1 expecting velocity
   logic [6:0]  m_key = '0;
   logic        m_gate = 1'b0;
   logic [6:0]  m_note = '0;
   logic [6:0]  m_vel = '0;
   logic [29:0] m_fccw = '0;

   midi_note_ctrl #(.PHASE_ACC_WIDTH(30), .CLK_HZ(100_000_000)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .midi_ch(midi_ch), .fccw(fccw), .gate(gate),
      .note_num(note_num), .velocity(velocity), .retrig(retrig), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [29:0] model_pitch(input int key);
      real f_hz;
      longint tbl;
      f_hz = 440.0 * $pow(2.0, real'(key % 12 + 51) / 12.0);
      tbl  = longint'(f_hz * 1073741824.0 / 100000000.0);
      return 30'(tbl >> (10 - key / 12));
   endfunction

   task automatic model_reset();
      m_run = 0; m_idx = 0; m_key = '0; m_gate = 1'b0;
      m_note = '0; m_vel = '0; m_fccw = '0;
   endtask

   // kind: 0 nothing visible, 1 orphan, 2 note-on, 3 matching note-off, 4 ignored note-off
   task automatic model_byte(input logic [7:0] b, output int kind);
      kind = 0;
      if (b >= 8'hF8) return;
      if (b[7]) begin
         if (b[3:0] == midi_ch && (b[7:4] == 4'h9 || b[7:4] == 4'h8)) m_run = int'(b[7:4]);
         else m_run = 0;
         m_idx = 0;
      end else if (m_run == 0) begin
         kind = 1;
      end else if (m_idx == 0) begin
         m_key = b[6:0];
         m_idx = 1;
      end else begin
         m_idx = 0;
         if (m_run == 9 && b != 8'h00) begin
            kind = 2; m_gate = 1'b1; m_note = m_key; m_vel = b[6:0];
            m_fccw = model_pitch(int'(m_key));
         end else if (m_key == m_note) begin
            kind = 3; m_gate = 1'b0;
         end else begin
            kind = 4;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      w = 0;
      @(negedge clk);
      rx_data = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && w < 40) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (rx_ready !== 1'b1) begin
         bad++;
         $display("FAIL accept_timeout byte=%02h rx_ready=%b need 1", b, rx_ready);
      end
      @(posedge clk);
      #1;
      last_acc = cyc;
      rx_valid = 1'b0;
   endtask

   task automatic drive(input logic [7:0] b, output int kind);
      send_byte(b);
      model_byte(b, kind);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({fccw, gate, note_num, velocity, retrig, err, rx_ready} !== {30'd0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_hold fccw=%0d gate=%b note=%0d vel=%0d retrig=%b err=%b rdy=%b need all zero rdy=1",
                  fccw, gate, note_num, velocity, retrig, err, rx_ready);
      end
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      total++;
      if ({fccw, gate, note_num, retrig, err, rx_ready} !== {30'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_release fccw=%0d gate=%b note=%0d rdy=%b need 0 0 0 1", fccw, gate, note_num, rx_ready);
      end
      $display("reset: done");
   endtask

   task automatic test_note_on();
      int k;
      drive(8'h90, k); drive(8'h45, k); drive(8'h64, k);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         total++;
         if (rx_ready !== 1'b0 || gate !== 1'b0 || retrig !== 1'b0 || fccw !== 30'd0) begin
            bad++;
            $display("FAIL calc_busy T+%0d rdy=%b gate=%b retrig=%b fccw=%0d need 0 0 0 0", i, rx_ready, gate, retrig, fccw);
         end
      end
      @(negedge clk);
      total++;
      if ({fccw, note_num, velocity, gate, retrig, rx_ready} !== {30'd4724, 7'd69, 7'd100, 1'b1, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL note_on_T12 fccw=%0d note=%0d vel=%0d gate=%b retrig=%b rdy=%b need 4724 69 100 1 1 1",
                  fccw, note_num, velocity, gate, retrig, rx_ready);
      end
      @(negedge clk);
      total++;
      if (retrig !== 1'b0 || gate !== 1'b1) begin
         bad++;
         $display("FAIL retrig_one_cycle retrig=%b gate=%b need 0 1", retrig, gate);
      end
      $display("note_on: 90 45 64 -> fccw=%0d note=%0d vel=%0d", fccw, note_num, velocity);
   endtask

   task automatic test_running_off();
      int k;
      drive(8'h45, k); drive(8'h00, k);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (gate !== 1'b0 || fccw !== 30'd4724 || note_num !== 7'd69) begin
         bad++;
         $display("FAIL running_off gate=%b fccw=%0d note=%0d need 0 4724 69", gate, fccw, note_num);
      end
      $display("running_off: 45 00 -> gate=%b fccw=%0d", gate, fccw);
   endtask

   task automatic test_last_note();
      int k;
      drive(8'h90, k); drive(8'h3C, k); drive(8'h40, k);
      repeat (13) @(negedge clk);
      total++;
      if (gate !== 1'b1 || note_num !== 7'd60 || fccw !== model_pitch(60) || velocity !== 7'd64) begin
         bad++;
         $display("FAIL note_on_3c gate=%b note=%0d fccw=%0d vel=%0d need 1 60 %0d 64", gate, note_num, fccw, velocity, model_pitch(60));
      end
      drive(8'h80, k); drive(8'h3E, k); drive(8'h00, k);
      repeat (3) @(negedge clk);
      total++;
      if (gate !== 1'b1) begin
         bad++;
         $display("FAIL off_other_key gate=%b need 1", gate);
      end
      drive(8'h80, k); drive(8'h3C, k); drive(8'h00, k);
      repeat (2) @(negedge clk);
      total++;
      if (gate !== 1'b0 || note_num !== 7'd60) begin
         bad++;
         $display("FAIL off_same_key gate=%b note=%0d need 0 60", gate, note_num);
      end
      $display("last_note: gate=%b note=%0d", gate, note_num);
   endtask

   task automatic test_other_channel();
      int k;
      logic [7:0] seq [4];
      seq = '{8'h91, 8'h45, 8'h64, 8'h45};
      foreach (seq[i]) begin
         drive(seq[i], k);
         @(negedge clk);
         total++;
         if (err !== (i > 0) || gate !== m_gate || note_num !== m_note || fccw !== m_fccw) begin
            bad++;
            $display("FAIL other_ch byte=%02h err=%b gate=%b note=%0d need err=%b gate=%b note=%0d",
                     seq[i], err, gate, note_num, (i > 0), m_gate, m_note);
         end
         @(negedge clk);
         total++;
         if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_one_cycle byte=%02h err=%b need 0", seq[i], err);
         end
      end
      $display("other_channel: gate=%b note=%0d", gate, note_num);
   endtask

   task automatic test_realtime_hold();
      int k, t_on;
      logic [7:0] seq [5];
      seq = '{8'h90, 8'hF8, 8'h45, 8'hFE, 8'h64};
      foreach (seq[i]) drive(seq[i], k);
      t_on = last_acc;
      drive(8'h3C, k);
      total++;
      if (last_acc - t_on !== 13) begin
         bad++;
         $display("FAIL hold_during_calc accepted after %0d cycles need 13", last_acc - t_on);
      end
      @(negedge clk);
      total++;
      if ({fccw, note_num, velocity, gate, retrig} !== {30'd4724, 7'd69, 7'd100, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL realtime_note fccw=%0d note=%0d vel=%0d gate=%b retrig=%b need 4724 69 100 1 0",
                  fccw, note_num, velocity, gate, retrig);
      end
      drive(8'h00, k);
      repeat (2) @(negedge clk);
      total++;
      if (gate !== 1'b1) begin
         bad++;
         $display("FAIL held_byte_off gate=%b need 1", gate);
      end
      $display("realtime_hold: fccw=%0d gate=%b", fccw, gate);
   endtask

   task automatic test_reset_in_calc();
      int k;
      drive(8'h90, k); drive(8'h30, k); drive(8'h50, k);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      total++;
      if ({fccw, gate, note_num, velocity, retrig, err, rx_ready} !== {30'd0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_in_calc fccw=%0d gate=%b note=%0d vel=%0d rdy=%b need 0 0 0 0 1",
                  fccw, gate, note_num, velocity, rx_ready);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if (retrig !== 1'b0 || gate !== 1'b0 || fccw !== 30'd0 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL after_abort cyc=%0d retrig=%b gate=%b fccw=%0d rdy=%b need 0 0 0 1",
                     i, retrig, gate, fccw, rx_ready);
         end
      end
      $display("reset_in_calc: outputs cleared, no late retrig");
   endtask

   task automatic test_random();
      int k, r;
      logic [7:0] b;
      midi_ch = 4'($urandom_range(0, 15));
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 99);
         if (r < 15)      b = {4'h9, midi_ch};
         else if (r < 22) b = {4'h8, midi_ch};
         else if (r < 30) b = {(r[0] ? 4'h9 : 4'h8), 4'($urandom_range(0, 15))};
         else if (r < 36) b = 8'($urandom_range(8'hA0, 8'hF7));
         else if (r < 42) b = 8'($urandom_range(8'hF8, 8'hFF));
         else if (r < 50) b = 8'h00;
         else             b = 8'($urandom_range(0, 127));
         drive(b, k);
         if (k == 2) begin
            for (int i = 0; i < 12; i++) begin
               @(negedge clk);
               total++;
               if (rx_ready !== 1'b0 || retrig !== 1'b0) begin
                  bad++;
                  $display("FAIL rand_busy n=%0d T+%0d rdy=%b retrig=%b need 0 0", n, i, rx_ready, retrig);
               end
            end
            @(negedge clk);
            total++;
            if ({fccw, note_num, velocity, gate, retrig, rx_ready} !== {m_fccw, m_note, m_vel, 1'b1, 1'b1, 1'b1}) begin
               bad++;
               $display("FAIL rand_note_on n=%0d fccw=%0d note=%0d vel=%0d gate=%b retrig=%b need %0d %0d %0d 1 1",
                        n, fccw, note_num, velocity, gate, retrig, m_fccw, m_note, m_vel);
            end
         end else if (k == 1) begin
            @(negedge clk);
            total++;
            if (err !== 1'b1) begin
               bad++;
               $display("FAIL rand_err n=%0d byte=%02h err=%b need 1", n, b, err);
            end
            @(negedge clk);
            total++;
            if (err !== 1'b0) begin
               bad++;
               $display("FAIL rand_err_clear n=%0d err=%b need 0", n, err);
            end
         end else if (k == 3) begin
            repeat (2) @(negedge clk);
            total++;
            if (gate !== 1'b0 || note_num !== m_note || fccw !== m_fccw) begin
               bad++;
               $display("FAIL rand_off n=%0d gate=%b note=%0d fccw=%0d need 0 %0d %0d", n, gate, note_num, fccw, m_note, m_fccw);
            end
         end else begin
            @(negedge clk);
            total++;
            if (err !== 1'b0 || retrig !== 1'b0 || gate !== m_gate || note_num !== m_note || rx_ready !== 1'b1) begin
               bad++;
               $display("FAIL rand_quiet n=%0d byte=%02h err=%b retrig=%b gate=%b note=%0d need 0 0 %b %0d",
                        n, b, err, retrig, gate, note_num, m_gate, m_note);
            end
         end
      end
      $display("random: 250 bytes, midi_ch=%0d, final note=%0d gate=%b", midi_ch, note_num, gate);
   endtask

   initial begin
      test_reset();
      test_note_on();
      test_running_off();
      test_last_note();
      test_other_channel();
      test_realtime_hold();
      test_reset_in_calc();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout reached need finish earlier");
      $fatal(1, "timeout");
   end

endmodule
